ins_cache: RTL
==============

INS_CACHE -- requirements
Module: ins_cache

Interface
REQ-001 Parameter ADR_W, default 17, byte-address width (matches RAM_ADR_W).
REQ-002 Parameter IDX_W, default 5, line-index width (2^IDX_W lines; line size fixed at 16 bytes).
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  global ready; when low, state, arrays and outputs hold.
REQ-006 if_en_i  input  1  fetch request pulse from fetcher.
REQ-007 if_pc_i  input  ADR_W  fetch address, halfword aligned.
REQ-008 flush_i  input  1  branch redirect; abandons outstanding request.
REQ-009 if_en_o  output  1  one-cycle response-valid pulse.
REQ-010 if_ins_o  output  32  instruction bits starting at requested pc.
REQ-011 mc_en_o  output  1  line refill request, level, held until done.
REQ-012 mc_adr_o  output  ADR_W  refill line address, bits[3:0]=0.
REQ-013 mc_done_i  input  1  refill complete pulse, mc_line_i valid this cycle.
REQ-014 mc_line_i  input  128  refilled line, byte k at bits[8k+7:8k].

Function
REQ-015 Organisation SHALL be direct-mapped: offset pc[3:0], index pc[IDX_W+3:4], tag pc[ADR_W-1:IDX_W+4]; per line: valid bit, tag, 128-bit data.
REQ-016 FSM states SHALL be IDLE, MISS_LO, MISS_HI, RESP.
REQ-017 Request accepted only in IDLE with en=1, if_en_i=1, flush_i=0; requests in other states ignored; pc latched on acceptance.
REQ-018 Line A = line of pc; line B = next line (line address +1, wrapping from all-ones to 0); B needed only when pc[3:1]=3'b111.
REQ-019 Output data: pc[3:1]!=7 -> A bytes [off+3:off]; pc[3:1]=7 -> {B[15:0], A[127:112]}.
REQ-020 Hit (A hit, and B hit if needed) at acceptance edge: next cycle if_en_o=1 with data (latency 1), state stays IDLE.
REQ-021 A miss: -> MISS_LO, mc_en_o=1, mc_adr_o=A address, held until mc_done_i.
REQ-022 On mc_done_i in MISS_LO: write line A, set valid/tag; then -> MISS_HI if B needed and missing, else -> RESP.
REQ-023 A hit, B needed and missing: -> MISS_HI directly; MISS_HI requests line B identically, on done writes B, -> RESP.
REQ-024 mc_en_o SHALL drop in the cycle after mc_done_i; no back-to-back assertion without at least one low cycle.
REQ-025 RESP: assert if_en_o one cycle with data from updated arrays, -> IDLE.
REQ-026 flush_i in IDLE: cancel any response scheduled at that edge.
REQ-027 flush_i in MISS_LO/MISS_HI: set drop flag; refill continues to mc_done_i and line is written; then -> IDLE with no response and no second refill.
REQ-028 flush_i in RESP: if_en_o suppressed, -> IDLE.
REQ-029 flush_i and if_en_i same cycle: flush wins, request ignored.
REQ-030 A and B mapping to same index (IDX_W=0 case excluded): not supported; IDX_W>=1 required.
REQ-031 en=0 while mc_done_i pulses: pulse lost; memory side SHALL not pulse done while en=0 (system rule).

Reset
REQ-032 rst=0 SHALL immediately force state IDLE, all valid bits 0, drop flag 0, if_en_o=0, if_ins_o=0, mc_en_o=0, mc_adr_o=0; data/tag arrays not reset.
REQ-033 Reset mid-refill SHALL abandon it; mc_en_o low while rst=0; first post-reset request treated as miss.

Verification
REQ-034 Cold miss: pc=0x00010 -> mc_en_o=1, mc_adr_o=0x00010; done with line 0x33221100_...; next cycle RESP if_en_o=1, if_ins_o per REQ-019.
REQ-035 Hit latency: re-request pc=0x00014 -> if_en_o=1 exactly 1 cycle later, mc_en_o stays 0.
REQ-036 Straddle: pc=0x0002E, both lines cold -> refills 0x00020 then 0x00030, if_ins_o={line30[15:0], line20[127:112]}.
REQ-037 Wrap: pc=0x1FFFE (ADR_W=17) -> second refill mc_adr_o=0x00000.
REQ-038 Flush during MISS_LO: flush_i 2 cycles after request -> refill completes, no if_en_o; next request to same pc hits in 1 cycle.
REQ-039 Async reset asserted in MISS_HI -> mc_en_o=0 same cycle; post-reset request to previously filled pc misses.

Source files
------------

// File: rtl/ins_cache.sv
// rtl/ins_cache.sv - direct-mapped instruction cache, 16-byte lines, two-line refill for straddling fetches
module ins_cache #(
    parameter int ADR_W = 17,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             if_en_i,
    input  logic [ADR_W-1:0] if_pc_i,
    input  logic             flush_i,
    output logic             if_en_o,
    output logic [31:0]      if_ins_o,
    output logic             mc_en_o,
    output logic [ADR_W-1:0] mc_adr_o,
    input  logic             mc_done_i,
    input  logic [127:0]     mc_line_i
);
    localparam int LA_W  = ADR_W - 4;
    localparam int TAG_W = ADR_W - IDX_W - 4;
    localparam int LINES = 1 << IDX_W;

    typedef enum logic [1:0] {IDLE, MISS_LO, MISS_HI, RESP} state_t;

    state_t state, state_nxt;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [127:0]      data_q [LINES];

    logic [ADR_W-1:1]  pc_q;
    logic [ADR_W-1:1]  rd_pc;
    logic              pc_unused;
    logic              drop_q;
    logic              hit_q;
    logic [31:0]       ins_q;

    logic [LA_W-1:0]   line_a, line_b;
    logic [IDX_W-1:0]  idx_a, idx_b, wr_idx;
    logic [TAG_W-1:0]  tag_a, tag_b, wr_tag;
    logic [127:0]      line_a_d, line_b_d;
    logic [31:0]       rd_ins;
    logic              need_b, a_hit, b_hit, b_miss, accept, drop_now, wr_en;

    // Lookups use the live pc while idle and the latched pc once a request is in flight.
    assign rd_pc     = (state == IDLE) ? if_pc_i[ADR_W-1:1] : pc_q;
    assign pc_unused = if_pc_i[0];

    assign line_a = rd_pc[ADR_W-1:4];
    assign line_b = line_a + LA_W'(1);
    assign idx_a  = line_a[IDX_W-1:0];
    assign idx_b  = line_b[IDX_W-1:0];
    assign tag_a  = line_a[LA_W-1:IDX_W];
    assign tag_b  = line_b[LA_W-1:IDX_W];

    assign need_b   = &rd_pc[3:1];
    assign a_hit    = valid[idx_a] && (tag_q[idx_a] == tag_a);
    assign b_hit    = valid[idx_b] && (tag_q[idx_b] == tag_b);
    assign b_miss   = need_b && !b_hit;
    assign accept   = en && if_en_i && !flush_i && (state == IDLE);
    assign drop_now = drop_q || flush_i;

    assign line_a_d = data_q[idx_a];
    assign line_b_d = data_q[idx_b];

    always_comb begin
        rd_ins = '0;
        if (need_b) begin
            rd_ins = {line_b_d[15:0], line_a_d[127:112]};
        end else begin
            rd_ins = line_a_d[{rd_pc[3:1], 4'b0000} +: 32];
        end
    end

    assign wr_en  = en && mc_done_i && ((state == MISS_LO) || (state == MISS_HI));
    assign wr_idx = (state == MISS_LO) ? idx_a : idx_b;
    assign wr_tag = (state == MISS_LO) ? tag_a : tag_b;

    always_comb begin
        state_nxt = state;
        if (en) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!a_hit) begin
                            state_nxt = MISS_LO;
                        end else if (b_miss) begin
                            state_nxt = MISS_HI;
                        end
                    end
                end
                MISS_LO: begin
                    if (mc_done_i) begin
                        if (drop_now) begin
                            state_nxt = IDLE;
                        end else if (b_miss) begin
                            state_nxt = MISS_HI;
                        end else begin
                            state_nxt = RESP;
                        end
                    end
                end
                MISS_HI: begin
                    if (mc_done_i) begin
                        state_nxt = drop_now ? IDLE : RESP;
                    end
                end
                RESP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid    <= '0;
            drop_q   <= 1'b0;
            hit_q    <= 1'b0;
            ins_q    <= '0;
            pc_q     <= '0;
            mc_en_o  <= 1'b0;
            mc_adr_o <= '0;
        end else if (en) begin
            hit_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        pc_q   <= rd_pc;
                        drop_q <= 1'b0;
                        if (!a_hit) begin
                            mc_en_o  <= 1'b1;
                            mc_adr_o <= {line_a, 4'h0};
                        end else if (b_miss) begin
                            mc_en_o  <= 1'b1;
                            mc_adr_o <= {line_b, 4'h0};
                        end else begin
                            hit_q <= 1'b1;
                            ins_q <= rd_ins;
                        end
                    end
                end
                MISS_LO: begin
                    if (flush_i) begin
                        drop_q <= 1'b1;
                    end
                    if (mc_done_i) begin
                        // Line B, if needed, is requested only after one idle cycle on mc_en_o.
                        mc_en_o       <= 1'b0;
                        valid[idx_a]  <= 1'b1;
                        drop_q        <= 1'b0;
                        if (!drop_now && b_miss) begin
                            mc_adr_o <= {line_b, 4'h0};
                        end
                    end else begin
                        mc_en_o <= 1'b1;
                    end
                end
                MISS_HI: begin
                    if (flush_i) begin
                        drop_q <= 1'b1;
                    end
                    if (mc_done_i) begin
                        mc_en_o      <= 1'b0;
                        valid[idx_b] <= 1'b1;
                        drop_q       <= 1'b0;
                    end else begin
                        mc_en_o <= 1'b1;
                    end
                end
                RESP: begin
                    if (!flush_i) begin
                        ins_q <= rd_ins;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_idx] <= mc_line_i;
            tag_q[wr_idx]  <= wr_tag;
        end
    end

    assign if_en_o  = hit_q || ((state == RESP) && !flush_i);
    assign if_ins_o = (state == RESP) ? rd_ins : ins_q;

endmodule
